// File: rtl/antares_timer_slave_if.sv
// antares_timer_slave_if: data-port handshake between the core and a memory-mapped responder
interface antares_timer_slave_if;
  logic [31:0] address;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic [3:0]  wr;
  logic        enable;
  logic        ready;
  logic        error;
  modport master (output address, data_i, wr, enable, input data_o, ready, error);
  modport slave  (input address, data_i, wr, enable, output data_o, ready, error);
endinterface

// File: rtl/antares_timer_slave.sv
// antares_timer_slave: memory-mapped prescaled 32-bit timer with compare match,
// auto-reload/one-shot modes and a level interrupt, behind a wait-state handshake.
module antares_timer_slave #(
  parameter int WAIT_STATES = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  antares_timer_slave_if.slave        bus,
  output logic                        irq
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t state, nxt;
  logic [3:0]  wcnt;
  logic [2:0]  a_q, sel;
  logic [3:0]  wr_q;
  logic [31:0] d_q, rdata, wdata, compare, count;
  logic [15:0] prescale, pre;
  logic [2:0]  ctrl;
  logic        pend, tick, match, wc, w1c, unused_addr;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? d[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  assign unused_addr = ^{bus.address[31:5], bus.address[1:0]};
  assign irq   = pend & ctrl[1];
  // In IDLE the request is decoded live so a zero-wait access can respond on the next edge.
  assign sel   = state == S_IDLE ? bus.address[4:2] : a_q;
  assign rdata = sel == 3'd0 ? {29'd0, ctrl} :
                 sel == 3'd1 ? {16'd0, prescale} :
                 sel == 3'd2 ? compare :
                 sel == 3'd3 ? count :
                 sel == 3'd4 ? {31'd0, pend} : 32'd0;
  // In RESP sel is the held offset, so rdata is the addressed register's current value.
  assign wdata = merge(rdata, d_q, wr_q);
  assign wc    = state == S_RESP && |wr_q;
  assign w1c   = wc && a_q == 3'd4 && wr_q[0] && d_q[0];
  assign tick  = ctrl[0] && pre == prescale;
  assign match = tick && count == compare;

  always_comb begin
    nxt = S_IDLE;
    if (state == S_IDLE)
      nxt = bus.enable ? ((WAIT_STATES > 0) ? S_WAIT : S_RESP) : S_IDLE;
    else if (state == S_WAIT)
      nxt = !bus.enable ? S_IDLE : (wcnt == 4'(WAIT_STATES - 1) ? S_RESP : S_WAIT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt       <= '0;
      a_q        <= '0;
      wr_q       <= '0;
      d_q        <= '0;
      bus.ready  <= 1'b0;
      bus.error  <= 1'b0;
      bus.data_o <= '0;
      ctrl       <= '0;
      prescale   <= '0;
      pre        <= '0;
      compare    <= '0;
      count      <= '0;
      pend       <= 1'b0;
    end else begin
      wcnt <= (state == S_WAIT && nxt == S_WAIT) ? wcnt + 4'd1 : 4'd0;
      if (state == S_IDLE && bus.enable) begin
        a_q  <= bus.address[4:2];
        wr_q <= bus.wr;
        d_q  <= bus.data_i;
      end
      bus.ready  <= nxt == S_RESP;
      bus.error  <= nxt == S_RESP && sel > 3'd4;
      bus.data_o <= nxt == S_RESP ? rdata : 32'd0;
      pre        <= (ctrl[0] && !tick) ? pre + 16'd1 : 16'd0;
      // A CTRL write wins over the one-shot disable landing on the same edge.
      ctrl       <= (wc && a_q == 3'd0 && wr_q[0]) ? wdata[2:0] :
                    (match && !ctrl[2]) ? {ctrl[2:1], 1'b0} : ctrl;
      prescale   <= (wc && a_q == 3'd1) ? wdata[15:0] : prescale;
      compare    <= (wc && a_q == 3'd2) ? wdata : compare;
      count      <= (wc && a_q == 3'd3) ? wdata : tick ? (match ? 32'd0 : count + 32'd1) : count;
      pend       <= match | (pend & !w1c);
    end
  end
endmodule

// File: doc/antares_timer_slave.md
# antares_timer_slave

Memory-mapped timer peripheral that acts as a responder on the core's data-port handshake (address/enable/wr in; data/ready/error out). It sits beside `memory` behind an external address decoder. It provides a prescaled 32-bit counter with compare match, auto-reload or one-shot mode, and a level interrupt that feeds one bit of the core's `interrupts[4:0]`. Access latency is configurable through wait states, so the bench can exercise the core's stall path.

## Interface
- `WAIT_STATES`, default 0: extra cycles inserted before `ready` (0–15).
- `clk` input, 1 bit: single clock for all logic.
- `rst` input, 1 bit: reset, asynchronous, active-low.
- `address` input, 32 bits: byte address; only `[4:2]` is decoded.
- `data_i` input, 32 bits: write data from the initiator.
- `wr` input, 4 bits: byte write enables; `4'b0000` means read.
- `enable` input, 1 bit: request valid; the external decoder asserts it only when this block is selected.
- `data_o` output, 32 bits: read data, valid while `ready` is high.
- `ready` output, 1 bit: one-cycle completion strobe.
- `error` output, 1 bit: high together with `ready` for an unmapped offset.
- `irq` output, 1 bit: interrupt, `STATUS.pend & CTRL.ie`.

## Operation
- Register map (offset `address[4:2]`):
  - 0: CTRL. Bit 0 `en`, bit 1 `ie`, bit 2 `auto`. Other bits read 0.
  - 1: PRESCALE, `[15:0]`.
  - 2: COMPARE, `[31:0]`.
  - 3: COUNT, `[31:0]`.
  - 4: STATUS. Bit 0 `pend`; write 1 to clear.
  - 5–7: unmapped. Reads and writes complete with `error=1`, `data_o=0`, no state change.
- Writes are per byte: a byte lane is updated only where `wr[i]=1`. For STATUS, the clear takes effect only when `wr[0]=1` and `data_i[0]=1`.
- Prescaler: the internal counter `pre` counts 0..PRESCALE while `en=1`. `tick` is high in the cycle where `pre==PRESCALE`; on that cycle `pre` wraps to 0. While `en=0`, `pre` is held at 0.
- On `tick`:
  - If COUNT≠COMPARE, COUNT increments by 1, modulo 2^32.
  - If COUNT==COMPARE, `pend` is set and COUNT goes to 0.
  - In that match case, if `auto=0`, CTRL.`en` is also cleared (one-shot).
- Match period: (COMPARE+1)·(PRESCALE+1) cycles.
- Priority when events coincide on the same edge:
  - A bus write to COUNT or PRESCALE overrides the tick update.
  - A match still sets `pend`, evaluated on the pre-write COUNT.
  - Set of `pend` beats a same-cycle write-1-clear.
  - A bus write to CTRL beats the one-shot clear of `en`.
- Handshake FSM:
  - IDLE → WAIT when `enable=1`, if `WAIT_STATES>0`. IDLE → RESP when `enable=1`, if `WAIT_STATES=0`.
  - WAIT counts `WAIT_STATES` cycles, then goes to RESP. WAIT goes to IDLE with no effect if `enable` drops (abort).
  - RESP lasts one cycle with `ready=1`, then always returns to IDLE. Sampling a new request in RESP is not allowed.
- Address, `wr` and `data_i` are sampled at the IDLE exit edge and held internally. The initiator holds its signals until `ready`.
- Read data is captured on entry to RESP. A write commits on the RESP→IDLE edge.
- Reset (asynchronous, active-low, any time, including mid-transaction):
  - FSM goes to IDLE; all registers, `pre` and `pend` go to 0.
  - `ready`, `error`, `irq` = 0 and `data_o` = 0.

## Timing
- All outputs are registered; `irq` is combinational from registered state only.
- Minimum access: `enable` sampled at edge k; `ready` is high during cycle k+1+WAIT_STATES; the write is visible on the read-back path from the next edge.
- Back-to-back accesses take WAIT_STATES+2 cycles each, because RESP always returns to IDLE.
- `ready` is never high for two consecutive cycles.
- `error` is never high without `ready`.
- `irq` rises in the cycle after the matching tick edge. It falls in the cycle after the W1C commit, or after `ie` is cleared.

## Test plan
- **Read-after-reset.** Release reset, then read offsets 0–4. Every read returns 0 with `error=0`; `ready` appears exactly 1 cycle after `enable` with `WAIT_STATES=0`, and 1+3 cycles with `WAIT_STATES=3`.
- **Byte writes.** Write COMPARE `32'hAABBCCDD` with `wr=4'b1111`, then write `32'h11223344` with `wr=4'b0101`. Read back gives `32'hAA22CC44`.
- **Auto-reload.** Set PRESCALE=1, COMPARE=4, CTRL=`3'b111`.
  - `pend` and `irq` assert 10 cycles after `en` rises, then again every 10 cycles.
  - W1C to STATUS drops `irq` one cycle after the commit.
- **One-shot.** Set CTRL=`3'b011`, PRESCALE=0, COMPARE=2. One match occurs after 3 cycles; afterwards CTRL reads `3'b010` and COUNT stays 0.
- **Collisions.**
  - W1C to STATUS on the same edge as a match: `pend` stays 1.
  - Write of COUNT=7 on a tick edge: COUNT reads 7.
- **Error and abort.**
  - Read offset 6: `ready=1`, `error=1`, `data_o=0`.
  - Drop `enable` mid-WAIT with `WAIT_STATES=3`: no `ready` and no write.
  - Assert reset mid-WAIT: all outputs 0 immediately.
